// File: rtl/mem_responder.sv
// Memory-side responder for a multicycle CPU.
// Serves one read or write at a time from a unified word array after a fixed
// number of wait states, using a 4-phase request/ready handshake. A preload
// port fills the array while the block is idle.
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Wait-state count loaded at accept; the counter is 4 bits wide.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  // With no wait states the access commits on the accept edge itself.
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  state_t            state;
  logic [3:0]        cnt;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_one;
  logic              req_both;
  logic              in_range;
  logic              accept;
  logic              reject;
  logic              go_resp;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              mem_we;
  logic              rd_en;
  logic              ld_we;
  logic [DATA_W-1:0] rd_word;

  // Request decode: what the IDLE state would do with the current inputs.
  always_comb begin
    req_one  = memRead ^ memWrite;
    req_both = memRead & memWrite;
    in_range = ({1'b0, addr} < DEPTH_L);
    ld_we    = (state == ST_IDLE) && ld_en;
    accept   = (state == ST_IDLE) && !ld_en && req_one && in_range;
    reject   = (state == ST_IDLE) && !ld_en && (req_both || (req_one && !in_range));
  end

  // Select the operands of the committing access: live inputs when the
  // access commits on the accept edge, latched copies otherwise.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_write = memWrite;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_write = op_write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    go_resp = ((state == ST_WAIT) && (cnt == 4'd1)) || (accept && NO_WAIT);
    mem_we  = go_resp && acc_write;
    rd_en   = go_resp && !acc_write;
  end

  // Array read mux; out-of-range addresses never reach a commit.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (acc_addr == ADDR_W'(i)) rd_word = mem[i];
    end
  end

  // Word array: cleared on reset, written by preload or a committing write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_we && (ld_addr == ADDR_W'(i))) begin
          mem[i] <= ld_data;
        end else if (mem_we && (acc_addr == ADDR_W'(i))) begin
          mem[i] <= acc_wdata;
        end
      end
    end
  end

  // Request operands captured at accept; held unchanged for the whole access.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && !ld_en && (memRead || memWrite)) begin
      op_write_q <= memWrite;
      addr_q     <= addr;
      wdata_q    <= wdata;
    end
  end

  // Handshake FSM with registered ready/err/busy/rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rdata <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      if (rd_en) rdata <= rd_word;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt   <= WAIT_INIT;
            busy  <= 1'b1;
            state <= NO_WAIT ? ST_RESP : ST_WAIT;
          end else if (reject) begin
            err   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_RELEASE;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt==0 cannot occur here; treat it like the final wait state.
          if (cnt <= 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          ready <= 1'b1;
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Wait for the requester to drop so a held request is served once.
          if (!memRead && !memWrite) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a default build (WAIT_CYCLES=2, DEPTH=32)
// and a zero-wait build with a short array (WAIT_CYCLES=0, DEPTH=20).
module tb_mem_responder;

  logic       clk;
  logic       rst;
  // default build
  logic       memRead, memWrite, ld_en;
  logic [4:0] addr, ld_addr;
  logic [7:0] wdata, ld_data, rdata;
  logic       ready, err, busy;
  // zero-wait, DEPTH=20 build
  logic       memRead_z, memWrite_z, ld_en_z;
  logic [4:0] addr_z, ld_addr_z;
  logic [7:0] wdata_z, ld_data_z, rdata_z;
  logic       ready_z, err_z, busy_z;

  int total;
  int bad;
  int overlap;

  mem_responder #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .busy(busy), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  mem_responder #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .memRead(memRead_z), .memWrite(memWrite_z),
    .addr(addr_z), .wdata(wdata_z), .rdata(rdata_z), .ready(ready_z), .err(err_z),
    .busy(busy_z), .ld_en(ld_en_z), .ld_addr(ld_addr_z), .ld_data(ld_data_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ready and err must never be high together on either build
  always @(negedge clk) begin
    if (ready && err) overlap++;
    if (ready_z && err_z) overlap++;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         op;        // 0 preload, 1 read, 2 write, 3 read+write
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp_rdata; // rdata port after the access
    int         exp_lat;   // edges after accept edge until ready/err
    logic       exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input bit sel, input logic [4:0] a, input logic [7:0] d);
    if (sel) begin ld_en_z = 1'b1; ld_addr_z = a; ld_data_z = d; end
    else     begin ld_en   = 1'b1; ld_addr   = a; ld_data   = d; end
    @(posedge clk); #1;
    ld_en = 1'b0; ld_en_z = 1'b0;
  endtask

  task automatic set_req(input bit sel, input logic rd, input logic wr,
                         input logic [4:0] a, input logic [7:0] d);
    if (sel) begin memRead_z = rd; memWrite_z = wr; addr_z = a; wdata_z = d; end
    else     begin memRead   = rd; memWrite   = wr; addr   = a; wdata   = d; end
  endtask

  // Raise a request, wait (bounded) for ready or err, drop it, wait for idle.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [4:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rv,
                        output logic e, output int nr);
    logic r_s, e_s, b_s;
    lat = -1; rv = '0; e = 1'b0; nr = 0;
    set_req(sel, rd, wr, a, d);
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      r_s = sel ? ready_z : ready;
      e_s = sel ? err_z : err;
      if (r_s) begin lat = k; nr++; rv = sel ? rdata_z : rdata; end
      if (e_s) begin lat = k; e = 1'b1; end
    end
    set_req(sel, 1'b0, 1'b0, a, d);
    b_s = sel ? busy_z : busy;
    for (int k = 0; k < 10 && b_s; k++) begin
      @(posedge clk); #1;
      if (sel ? ready_z : ready) nr++;
      b_s = sel ? busy_z : busy;
    end
    if (b_s) check("idle_wait", 32'(b_s), 32'd0);
  endtask

  // Hold a request for n edges on the default build, counting pulses.
  task automatic hold_req(input logic rd, input logic wr, input logic [4:0] a,
                          input int n, output int nr, output int ne, output int nb);
    nr = 0; ne = 0; nb = 0;
    memRead = rd; memWrite = wr; addr = a;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (ready) nr++;
      if (err) ne++;
      if (!busy) nb++;
    end
    memRead = 1'b0; memWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  int         lat, nr, ne, nb;
  logic [7:0] rv;
  logic       e;

  initial begin
    total = 0; bad = 0; overlap = 0;
    rst = 1'b0;
    memRead = 0; memWrite = 0; addr = '0; wdata = '0; ld_en = 0; ld_addr = '0; ld_data = '0;
    memRead_z = 0; memWrite_z = 0; addr_z = '0; wdata_z = '0; ld_en_z = 0; ld_addr_z = '0; ld_data_z = '0;

    vecs[0]  = '{0, 5'd5,  8'hA7, 8'h00, 0, 1'b0};
    vecs[1]  = '{1, 5'd5,  8'h00, 8'hA7, 3, 1'b0};
    vecs[2]  = '{2, 5'd7,  8'h3C, 8'hA7, 3, 1'b0};
    vecs[3]  = '{1, 5'd7,  8'h00, 8'h3C, 3, 1'b0};
    vecs[4]  = '{3, 5'd7,  8'hFF, 8'h3C, 0, 1'b1};
    vecs[5]  = '{1, 5'd7,  8'h00, 8'h3C, 3, 1'b0};
    vecs[6]  = '{2, 5'd0,  8'h55, 8'h3C, 3, 1'b0};
    vecs[7]  = '{2, 5'd31, 8'hAA, 8'h3C, 3, 1'b0};
    vecs[8]  = '{1, 5'd31, 8'h00, 8'hAA, 3, 1'b0};
    vecs[9]  = '{1, 5'd0,  8'h00, 8'h55, 3, 1'b0};
    vecs[10] = '{0, 5'd31, 8'h11, 8'h00, 0, 1'b0};
    vecs[11] = '{1, 5'd31, 8'h00, 8'h11, 3, 1'b0};
    vecs[12] = '{2, 5'd31, 8'h22, 8'h11, 3, 1'b0};
    vecs[13] = '{1, 5'd31, 8'h00, 8'h22, 3, 1'b0};
    vecs[14] = '{1, 5'd12, 8'h00, 8'h00, 3, 1'b0};
    vecs[15] = '{1, 5'd5,  8'h00, 8'hA7, 3, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy_z",  32'(busy_z),  32'd0);
    check("rst_rdata_z", 32'(rdata_z), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a write's wait states
    load(1'b0, 5'd9, 8'h77);
    access(1'b0, 1'b1, 1'b0, 5'd9, 8'h00, lat, rv, e, nr);
    check("t1_pre_read", 32'(rv), 32'h77);
    memWrite = 1'b1; addr = 5'd3; wdata = 8'h5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t1_busy_wait", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t1_ready", 32'(ready), 32'd0);
    check("t1_err",   32'(err),   32'd0);
    check("t1_busy",  32'(busy),  32'd0);
    check("t1_rdata", 32'(rdata), 32'd0);
    memWrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 5'd3, 8'h00, lat, rv, e, nr);
    check("t1_read3_lat", 32'(lat), 32'd3);
    check("t1_read3", 32'(rv), 32'h00);
    access(1'b0, 1'b1, 1'b0, 5'd9, 8'h00, lat, rv, e, nr);
    check("t1_read9", 32'(rv), 32'h00);

    // Table of single accesses on the default build
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].op == 0) begin
        load(1'b0, vecs[i].a, vecs[i].d);
        check($sformatf("v%0d_ld_busy", i), 32'(busy), 32'd0);
      end else begin
        access(1'b0, (vecs[i].op == 1) || (vecs[i].op == 3),
               (vecs[i].op == 2) || (vecs[i].op == 3),
               vecs[i].a, vecs[i].d, lat, rv, e, nr);
        check($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
        check($sformatf("v%0d_err", i),   32'(e),   32'(vecs[i].exp_err));
        check($sformatf("v%0d_nready", i), 32'(nr), vecs[i].exp_err ? 32'd0 : 32'd1);
        check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      end
    end

    // Read held for 10 cycles past ready: served once, busy held
    hold_req(1'b1, 1'b0, 5'd5, 14, nr, ne, nb);
    check("hold_rd_nready", 32'(nr), 32'd1);
    check("hold_rd_nerr",   32'(ne), 32'd0);
    check("hold_rd_busylow", 32'(nb), 32'd0);
    check("hold_rd_rdata",  32'(rdata), 32'hA7);
    check("hold_rd_release", 32'(busy), 32'd0);

    // Both request lines held: one err pulse, no access, busy until both drop
    wdata = 8'hFF;
    hold_req(1'b1, 1'b1, 5'd7, 6, nr, ne, nb);
    check("hold_both_nerr",   32'(ne), 32'd1);
    check("hold_both_nready", 32'(nr), 32'd0);
    check("hold_both_busylow", 32'(nb), 32'd0);
    check("hold_both_release", 32'(busy), 32'd0);
    access(1'b0, 1'b1, 1'b0, 5'd7, 8'h00, lat, rv, e, nr);
    check("hold_both_mem", 32'(rv), 32'h3C);

    // Zero-wait, DEPTH=20 build
    load(1'b1, 5'd4, 8'h9C);
    access(1'b1, 1'b1, 1'b0, 5'd4, 8'h00, lat, rv, e, nr);
    check("z_read4_lat", 32'(lat), 32'd1);
    check("z_read4", 32'(rv), 32'h9C);
    access(1'b1, 1'b1, 1'b0, 5'd25, 8'h00, lat, rv, e, nr);
    check("z_oob_err", 32'(e), 32'd1);
    check("z_oob_lat", 32'(lat), 32'd0);
    check("z_oob_nready", 32'(nr), 32'd0);
    check("z_oob_rdata", 32'(rdata_z), 32'h9C);
    access(1'b1, 1'b0, 1'b1, 5'd19, 8'h44, lat, rv, e, nr);
    check("z_wr19_lat", 32'(lat), 32'd1);
    check("z_wr19_err", 32'(e), 32'd0);
    access(1'b1, 1'b1, 1'b0, 5'd19, 8'h00, lat, rv, e, nr);
    check("z_read19", 32'(rv), 32'h44);
    access(1'b1, 1'b0, 1'b1, 5'd20, 8'h66, lat, rv, e, nr);
    check("z_oob_wr_err", 32'(e), 32'd1);
    check("z_oob_wr_rdata", 32'(rdata_z), 32'h44);

    check("ready_err_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
